// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word via valid/ready
// and shifts it out one bit per bit_en cycle, streaming back-to-back words gaplessly.
module piso_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             bit_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   shreg;
   logic [CNT_W-1:0]   bit_cnt;
   logic               last_c;
   logic               accept_c;

   assign last_c     = (bit_cnt == LAST_BIT);
   assign load_ready = (state == IDLE) | ((state == SHIFT) & last_c & bit_en);
   assign accept_c   = load_valid & load_ready;

   // Frame sequencer: load on accept, shift on bit_en, reload on the last bit for gapless frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         shreg       <= '0;
         bit_cnt     <= '0;
         frame_start <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept_c) begin
                  shreg       <= load_data;
                  bit_cnt     <= '0;
                  frame_start <= 1'b1;
                  state       <= SHIFT;
               end else begin
                  frame_start <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_en) begin
                  if (!last_c) begin
                     bit_cnt     <= bit_cnt + CNT_W'(1);
                     shreg       <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
                     frame_start <= 1'b0;
                  end else if (accept_c) begin
                     shreg       <= load_data;
                     bit_cnt     <= '0;
                     frame_start <= 1'b1;
                  end else begin
                     bit_cnt     <= '0;
                     frame_start <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               frame_start <= 1'b0;
            end
         endcase
      end
   end

   // Output end of the shifter, gated off outside a frame
   assign ser_out   = (state == SHIFT) & (LSB_FIRST ? shreg[0] : shreg[WIDTH-1]);
   assign ser_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for the serial bit stream consumed by `shift_register`. A WIDTH-bit word is accepted through a valid/ready handshake and then driven onto `ser_out`, one bit per enabled clock. A bit counter and a two-state FSM sequence the frame. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `LSB_FIRST`, default 0: 0 sends bit WIDTH-1 first; 1 sends bit 0 first.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_data` input WIDTH: parallel word to transmit.
- `load_valid` input 1: `load_data` is valid this cycle.
- `load_ready` output 1: the block accepts a word this cycle.
- `bit_en` input 1: bit-rate strobe; one bit advances per cycle with `bit_en`=1. Tie high for full rate.
- `ser_out` output 1: serial data bit.
- `ser_valid` output 1: `ser_out` carries a frame bit.
- `frame_start` output 1: `ser_out` is the first bit of a frame.
- `busy` output 1: FSM is in SHIFT.

## Operation
- Registers:
  - `shreg[WIDTH-1:0]`
  - `bit_cnt`, width clog2(WIDTH)
  - `state` ∈ {IDLE, SHIFT}
- Accept condition: `load_valid & load_ready` at a rising edge.
- `load_ready` is combinational:
  - `load_ready = (state==IDLE) | (state==SHIFT & bit_cnt==WIDTH-1 & bit_en)`.
- IDLE:
  - On accept: `shreg ← load_data`, `bit_cnt ← 0`, `frame_start ← 1`, then go to SHIFT.
  - Otherwise stay in IDLE.
  - Accept in IDLE does not depend on `bit_en`.
- SHIFT, `bit_en`=0: hold all registers and outputs. `frame_start` stays as it was.
- SHIFT, `bit_en`=1 with `bit_cnt < WIDTH-1`:
  - `bit_cnt` increments.
  - `shreg` shifts one place toward the output end: left if LSB_FIRST=0, right if LSB_FIRST=1, zero-fill.
  - `frame_start ← 0`.
- SHIFT, `bit_en`=1 with `bit_cnt == WIDTH-1` (last bit):
  - On accept: reload `shreg`, `bit_cnt ← 0`, `frame_start ← 1`, stay in SHIFT. This gives a gapless frame.
  - With no accept: go to IDLE.
- `ser_out` = `shreg[WIDTH-1]` (LSB_FIRST=0) or `shreg[0]` (LSB_FIRST=1) while in SHIFT; forced to 0 in IDLE.
- `ser_valid` = `busy` = (state==SHIFT).
- `load_data` is sampled only at accept. Later changes to `load_data` do not affect the frame in flight.
- `load_valid` without `load_ready` is ignored; nothing is queued.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - state = IDLE, `shreg` = 0, `bit_cnt` = 0.
  - Outputs: `ser_out`=0, `ser_valid`=0, `frame_start`=0, `busy`=0, `load_ready`=1.
  - No accept while `rst_n`=0.
- Deasserting reset mid-frame: the frame is discarded. The block resumes in IDLE with no partial output.
- Latency: the first bit appears on `ser_out` in the cycle after the accept edge, with `ser_valid`=1 and `frame_start`=1.
- Frame length: exactly WIDTH cycles with `bit_en`=1. With `bit_en`=1 constantly, the frame occupies WIDTH consecutive cycles.
- Back-to-back: an accept on the last-bit edge puts the first bit of the next word in the very next cycle. `ser_valid` stays high and `frame_start` pulses for one cycle.
- `bit_en` low on the last bit: `load_ready` stays 0 and the last bit is held until `bit_en` rises.
- Throughput at full rate: one word per WIDTH cycles.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-frame, then release.
  - Response: all outputs 0 at once except `load_ready`=1; `ser_out` stays 0 afterwards with no stray bits.
- Single MSB-first word:
  - Stimulus: WIDTH=8, LSB_FIRST=0, `bit_en`=1, accept 8'hA5.
  - Response: next 8 cycles `ser_out` = 1,0,1,0,0,1,0,1; `frame_start` high only in the first of these cycles; `ser_valid` high for exactly those 8 cycles; `load_ready` high only in the 8th.
- LSB-first:
  - Stimulus: LSB_FIRST=1, accept 8'hA5.
  - Response: `ser_out` = 1,0,1,0,0,1,0,1 (bit 0 first). Stimulus: 8'h0F.
  - Response: 1,1,1,1,0,0,0,0.
- Back-to-back:
  - Stimulus: 8'h81 then 8'h7E, with `load_valid` held high.
  - Response: 16 contiguous valid cycles, `ser_out` = 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0; `frame_start` pulses in cycles 1 and 9.
- Bit-rate pacing:
  - Stimulus: `bit_en` high every 3rd cycle, accept 8'hC3.
  - Response: each bit is held 3 cycles, frame lasts 24 cycles; `load_ready`=0 until the last-bit `bit_en` cycle.
- Handshake ignore:
  - Stimulus: `load_valid` pulses mid-frame with 8'hFF.
  - Response: no change to the current frame; the word is not transmitted.
